// File: rtl/mem_stage_req.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_req
//  Description : Memory-access pipeline stage (EX -> MEM -> WB). Holds one
//                op in its own stage register. Issues it on a split
//                req/addr_ok/data_ok data-SRAM bus and stalls until the
//                access completes. It builds the byte strobes and the
//                lane-replicated store data. It shifts and extends load data
//                so that WB receives the final register value. A flush
//                drops the held op. If a bus transaction is already
//                accepted, the stale response is drained and never
//                forwarded.
//
//  Ports       : clk, rst (async, active high)
//                flush                     - discard held op
//                in_*                      - upstream op + valid/ready
//                out_*                     - result to WB + valid/ready
//                data_sram_*               - split-transaction SRAM bus
//
//  Config      : MEM_ALE_EN - when defined, a misaligned half/word access
//                raises out_ex instead of issuing a bus request.
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage_req #(
    parameter int               ADDR_W   = 32,
    parameter int               DEST_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h1c000000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_alu_result,
    input  logic [7:0]        in_op,
    input  logic              in_gr_we,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [31:0]       in_st_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_wb_data,
    output logic              out_gr_we,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_ex,

    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata
);

    // One-hot op bit positions
    localparam int c_LB  = 0;
    localparam int c_LH  = 1;
    localparam int c_LW  = 2;
    localparam int c_LBU = 3;
    localparam int c_LHU = 4;
    localparam int c_SB  = 5;
    localparam int c_SH  = 6;
    localparam int c_SW  = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_CANCEL = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_valid;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_alu;
    logic [7:0]          r_op;
    logic                r_gr_we;
    logic [DEST_W-1:0]   r_dest;
    logic [31:0]         r_st_data;
    logic [31:0]         r_rdata;

    logic                w_mem;
    logic                w_in_mem;
    logic                w_ale;
    logic                w_in_ale;
    logic                w_ready_go;
    logic                w_load;
    logic                w_in_issue;
    logic                w_capture;
    logic [31:0]         w_shifted;
    logic [31:0]         w_load_data;
    logic                w_is_load;

    // ------------------------------------------------------------------
    // Alignment exception detection
    // ------------------------------------------------------------------
`ifdef MEM_ALE_EN
    function automatic logic f_misaligned(input logic [7:0] op, input logic [1:0] a);
        return ((op[c_LH] | op[c_LHU] | op[c_SH]) & a[0])
             | ((op[c_LW] | op[c_SW]) & (a != 2'b00));
    endfunction
    assign w_in_ale = f_misaligned(in_op, in_alu_result[1:0]);
    assign w_ale    = f_misaligned(r_op, r_alu[1:0]);
`else
    assign w_in_ale = 1'b0;
    assign w_ale    = 1'b0;
`endif

    assign w_mem    = |r_op;
    assign w_in_mem = |in_op;

    // A trapping op never reaches the bus, so it completes like a non-mem op.
    assign w_ready_go = r_valid & (~w_mem | w_ale | (r_state == S_DONE));

    // A flush cycle accepts nothing, so a wrong-path op cannot slip in on
    // the same edge that discards the held one. CANCEL keeps the stage
    // closed until the orphaned response has drained.
    assign in_ready   = (r_state != S_CANCEL) & ~flush
                      & (~r_valid | (w_ready_go & out_ready));
    assign w_load     = in_valid & in_ready;
    assign w_in_issue = w_load & w_in_mem & ~w_in_ale;
    assign out_valid  = r_valid & w_ready_go & ~flush;

    // Response is captured whenever it belongs to a live (non-cancelled) op.
    assign w_capture  = data_sram_data_ok
                      & (((r_state == S_REQ) & data_sram_addr_ok) | (r_state == S_WAIT));

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_in_issue) w_state_next = S_REQ;
            end
            S_REQ: begin
                if (data_sram_addr_ok) begin
                    if (data_sram_data_ok) w_state_next = flush ? S_IDLE : S_DONE;
                    else                   w_state_next = flush ? S_CANCEL : S_WAIT;
                end else if (flush) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) w_state_next = flush ? S_IDLE : S_DONE;
                else if (flush)        w_state_next = S_CANCEL;
            end
            S_DONE: begin
                if (flush)          w_state_next = S_IDLE;
                else if (out_ready) w_state_next = w_in_issue ? S_REQ : S_IDLE;
            end
            S_CANCEL: begin
                if (data_sram_data_ok) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_pc      <= RESET_PC;
            r_alu     <= '0;
            r_op      <= '0;
            r_gr_we   <= 1'b0;
            r_dest    <= '0;
            r_st_data <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_next;

            if (flush)                          r_valid <= 1'b0;
            else if (w_load)                    r_valid <= 1'b1;
            else if (w_ready_go & out_ready)    r_valid <= 1'b0;

            if (w_load) begin
                r_pc      <= in_pc;
                r_alu     <= in_alu_result;
                r_op      <= in_op;
                r_gr_we   <= in_gr_we;
                r_dest    <= in_dest;
                r_st_data <= in_st_data;
            end

            if (w_capture) r_rdata <= data_sram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Bus request fields (stable while in REQ because the stage is held)
    // ------------------------------------------------------------------
    assign data_sram_req  = (r_state == S_REQ);
    assign data_sram_addr = r_alu;
    assign data_sram_wr   = r_op[c_SB] | r_op[c_SH] | r_op[c_SW];

    always_comb begin
        data_sram_size = 2'd0;
        if (r_op[c_SH] | r_op[c_LH] | r_op[c_LHU]) data_sram_size = 2'd1;
        if (r_op[c_SW] | r_op[c_LW])               data_sram_size = 2'd2;
    end

    always_comb begin
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = r_st_data;
        if (r_op[c_SB]) begin
            data_sram_wstrb = 4'b0001 << r_alu[1:0];
            data_sram_wdata = {4{r_st_data[7:0]}};
        end else if (r_op[c_SH]) begin
            data_sram_wstrb = 4'b0011 << r_alu[1:0];
            data_sram_wdata = {2{r_st_data[15:0]}};
        end else if (r_op[c_SW]) begin
            data_sram_wstrb = 4'b1111;
        end
    end

    // ------------------------------------------------------------------
    // Load alignment / extension and writeback mux
    // ------------------------------------------------------------------
    assign w_shifted = r_rdata >> {r_alu[1:0], 3'b000};
    assign w_is_load = r_op[c_LB] | r_op[c_LH] | r_op[c_LW] | r_op[c_LBU] | r_op[c_LHU];

    always_comb begin
        w_load_data = w_shifted;
        if (r_op[c_LB])       w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
        else if (r_op[c_LH])  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
        else if (r_op[c_LBU]) w_load_data = {24'd0, w_shifted[7:0]};
        else if (r_op[c_LHU]) w_load_data = {16'd0, w_shifted[15:0]};
    end

    // On an alignment trap the writeback value carries the bad address.
    assign out_wb_data = (w_is_load & ~w_ale) ? w_load_data : 32'(r_alu);
    assign out_pc      = r_pc;
    assign out_dest    = r_dest;
    assign out_ex      = r_valid & w_ale;
    assign out_gr_we   = r_gr_we & ~out_ex;

endmodule
`default_nettype wire
